// File: rtl/mcycle_sequencer.sv
// mcycle_sequencer
//   Multi-cycle control sequencer for the MIPS core. Steps each instruction
//   through FETCH/DECODE/EXEC/(MEM)/(WB), gates the decoder's single-cycle
//   write enables, handshakes with a variable-latency shared memory, guards
//   memory waits with a timeout, handles halt requests and counts retired
//   instructions.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   dec_reg_wren       : decoder register-write request
//   dec_mem_wren       : decoder store indication (SW)
//   dec_reg_dmux_sel   : decoder data-mux select, 0 = load (LW)
//   mem_ready          : memory completes current request this cycle
//   halt_req           : stop at next instruction boundary
//   imem_req/dmem_req  : instruction / data memory request
//   dmem_we            : data access is a write
//   ir_wren            : capture instruction register
//   reg_wren, pc_wren  : gated register-file / PC write enables
//   state              : current state encoding
//   halted, fault      : in HALT / sticky memory-timeout flag
//   retired            : retired-instruction count (wraps)
module mcycle_sequencer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_reg_wren,
    input  logic             dec_mem_wren,
    input  logic             dec_reg_dmux_sel,
    input  logic             mem_ready,
    input  logic             halt_req,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_wren,
    output logic             reg_wren,
    output logic             pc_wren,
    output logic [2:0]       state,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    localparam logic [7:0]       WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wait_q    <= 8'd0;
            fault_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            fault_q   <= fault_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = 8'd0;   // outside a waiting FETCH/MEM the counter is held at 0, so every entry starts clean
        fault_d  = fault_q;
        retire   = 1'b0;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        ir_wren  = 1'b0;
        reg_wren = 1'b0;
        pc_wren  = 1'b0;

        case (state_q)
            S_IDLE: state_d = halt_req ? S_HALT : S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (mem_ready) begin
                    ir_wren = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (!dec_reg_dmux_sel || dec_mem_wren) state_d = S_MEM;
                else if (dec_reg_wren)                 state_d = S_WB;
                else                                   retire  = 1'b1;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_mem_wren;
                if (mem_ready) begin
                    if (dec_mem_wren) retire  = 1'b1;
                    else              state_d = S_WB;
                end else if (wait_q == WAIT_LAST) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                reg_wren = 1'b1;
                retire   = 1'b1;
            end
            S_HALT: if (!halt_req && !fault_q) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase

        // Retire is the only instruction boundary besides IDLE/HALT.
        if (retire) begin
            pc_wren = 1'b1;
            state_d = halt_req ? S_HALT : S_FETCH;
        end
    end

    assign retired_d = retire ? retired_q + CNT_ONE : retired_q;

    assign state   = state_q;
    assign halted  = (state_q == S_HALT);
    assign fault   = fault_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mcycle_sequencer.sv
module tb_mcycle_sequencer;

  localparam int A = 0, L = 1, S = 2, B = 3;

  logic       clk = 1'b0;
  logic       rst, dec_reg_wren, dec_mem_wren, dec_reg_dmux_sel, mem_ready, halt_req;
  logic       imem_req, dmem_req, dmem_we, ir_wren, reg_wren, pc_wren, halted, fault;
  logic [2:0] state;
  logic [3:0] retired;

  mcycle_sequencer #(.TIMEOUT_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .dec_reg_wren(dec_reg_wren), .dec_mem_wren(dec_mem_wren),
    .dec_reg_dmux_sel(dec_reg_dmux_sel), .mem_ready(mem_ready),
    .halt_req(halt_req), .imem_req(imem_req), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .ir_wren(ir_wren), .reg_wren(reg_wren),
    .pc_wren(pc_wren), .state(state), .halted(halted), .fault(fault),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, rw, mw, ds, rdy, hr;
    logic [14:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [14:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic void add(input int r, input int kind, input int rdy, input int hr,
                              input int st, input int im, input int dm, input int we,
                              input int ir, input int rw, input int pc, input int ft,
                              input int ret);
    vec_t v;
    v.rst = 1'(r);
    v.rdy = 1'(rdy);
    v.hr  = 1'(hr);
    v.rw  = (kind == A) || (kind == L);
    v.mw  = (kind == S);
    v.ds  = (kind != L);
    v.exp = {3'(st), 1'(im), 1'(dm), 1'(we), 1'(ir), 1'(rw), 1'(pc),
             1'(st == 6), 1'(ft), 4'(ret % 16)};
    vecs.push_back(v);
  endfunction

  function automatic void instr(input int kind, input int ret);
    add(0, kind, 1, 0, 1, 1, 0, 0, 1, 0, 0, 0, ret);
    add(0, kind, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, ret);
    case (kind)
      A: begin
        add(0, A, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, ret);
        add(0, A, 0, 0, 5, 0, 0, 0, 0, 1, 1, 0, ret);
      end
      S: begin
        add(0, S, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, ret);
        add(0, S, 1, 0, 4, 0, 1, 1, 0, 0, 1, 0, ret);
      end
      default: add(0, B, 1, 0, 3, 0, 0, 0, 0, 0, 1, 0, ret);
    endcase
  endfunction

  logic [14:0] got, e;

  initial begin
    rst = 1'b1; dec_reg_wren = 1'b0; dec_mem_wren = 1'b0;
    dec_reg_dmux_sel = 1'b1; mem_ready = 1'b0; halt_req = 1'b0;

    add(0, A, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) instr(A, k);
    add(0, L, 1, 0, 1, 1, 0, 0, 1, 0, 0, 0, 3);
    add(0, L, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 3);
    add(0, L, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 3);
    add(0, L, 0, 0, 4, 0, 1, 0, 0, 0, 0, 0, 3);
    add(0, L, 0, 0, 4, 0, 1, 0, 0, 0, 0, 0, 3);
    add(0, L, 1, 0, 4, 0, 1, 0, 0, 0, 0, 0, 3);
    add(0, L, 0, 0, 5, 0, 0, 0, 0, 1, 1, 0, 3);
    instr(S, 4);
    instr(B, 5);
    add(0, A, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 6);
    add(0, A, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 6);
    add(0, A, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 6);
    add(0, A, 1, 0, 1, 1, 0, 0, 1, 0, 0, 0, 6);
    add(0, A, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 6);
    add(0, A, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 6);
    add(0, A, 0, 0, 5, 0, 0, 0, 0, 1, 1, 0, 6);
    add(0, A, 1, 0, 1, 1, 0, 0, 1, 0, 0, 0, 7);
    add(0, A, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 7);
    add(0, A, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 7);
    add(0, A, 0, 1, 5, 0, 0, 0, 0, 1, 1, 0, 7);
    add(0, A, 0, 1, 6, 0, 0, 0, 0, 0, 0, 0, 8);
    add(0, A, 0, 0, 6, 0, 0, 0, 0, 0, 0, 0, 8);
    for (int k = 0; k < 4; k++) add(0, A, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 8);
    add(0, A, 0, 1, 6, 0, 0, 0, 0, 0, 0, 1, 8);
    add(0, A, 0, 0, 6, 0, 0, 0, 0, 0, 0, 1, 8);
    add(0, A, 0, 0, 6, 0, 0, 0, 0, 0, 0, 1, 8);
    add(1, A, 0, 0, 6, 0, 0, 0, 0, 0, 0, 1, 8);
    add(0, A, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 17; k++) instr(B, k);
    add(0, A, 1, 0, 1, 1, 0, 0, 1, 0, 0, 0, 1);
    add(0, A, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, A, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, A, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, A, 0, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, A, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (state !== 3'd0 || fault !== 1'b0 || retired !== 4'd0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset state: state=%0d fault=%b retired=%0d halted=%b",
               state, fault, retired, halted);
    end
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; dec_reg_wren = vecs[i].rw; dec_mem_wren = vecs[i].mw;
      dec_reg_dmux_sel = vecs[i].ds; mem_ready = vecs[i].rdy; halt_req = vecs[i].hr;
      exp_q.push_back(vecs[i].exp);
      @(negedge clk);
      got = {state, imem_req, dmem_req, dmem_we, ir_wren, reg_wren, pc_wren,
             halted, fault, retired};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL row%0d {st,imem,dmem,we,ir,regw,pcw,halted,fault,ret} got %b expected %b",
                 i, got, e);
      end
      checks++;
      if (got[4] !== e[4] || got[5] !== e[5] || (e[4] && ir_wren !== 1'b0)) begin
        errors++;
        $display("FAIL row%0d expired-wait: fault=%b halted=%b ir_wren=%b expected fault=%b halted=%b",
                 i, got[4], got[5], ir_wren, e[4], e[5]);
      end
      @(posedge clk);
      #1;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
